// File: rtl/din_syn_capture.sv
// Serial frame receiver: oversamples an external sclk/din/syn link on the
// system clock, deserialises each frame and checks its length.
module din_syn_capture #(
    parameter int unsigned TOTAL_BITS = 644,
    parameter int unsigned CNT_W      = 10,
    parameter int unsigned TIMEOUT    = 4095
) (
    input  logic                  clk_in,
    input  logic                  rst,
    input  logic                  sclk_in,
    input  logic                  din_in,
    input  logic                  syn_in,
    input  logic                  clr,
    output logic [TOTAL_BITS-1:0] rx_data,
    output logic                  frame_valid,
    output logic                  frame_err,
    output logic [1:0]            err_code,
    output logic                  busy,
    output logic [CNT_W-1:0]      bit_cnt,
    output logic [15:0]           frame_count
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        StIdle,
        StRecv,
        StOvf
    } state_e;

    logic [2:0] meta_q, sync_q;
    logic       sclk_d_q;
    logic       sclk_s, din_s, syn_s, edge_s;

    state_e                state_q, state_d;
    logic [TOTAL_BITS-1:0] shift_q, shift_d;
    logic [TOTAL_BITS-1:0] rx_data_q, rx_data_d;
    logic                  frame_valid_q, frame_valid_d;
    logic                  frame_err_q, frame_err_d;
    logic [1:0]            err_code_q, err_code_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [15:0]           frame_count_q, frame_count_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;

    // Two-flop synchronisers for {sclk, din, syn} plus the sclk edge delay flop.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            meta_q   <= '0;
            sync_q   <= '0;
            sclk_d_q <= 1'b0;
        end else begin
            meta_q   <= {sclk_in, din_in, syn_in};
            sync_q   <= meta_q;
            sclk_d_q <= sync_q[2];
        end
    end

    assign sclk_s = sync_q[2];
    assign din_s  = sync_q[1];
    assign syn_s  = sync_q[0];
    assign edge_s = sclk_s & ~sclk_d_q;

    // Receiver state and datapath registers.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            shift_q       <= '0;
            rx_data_q     <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            err_code_q    <= 2'b00;
            bit_cnt_q     <= '0;
            frame_count_q <= '0;
            tmo_q         <= '0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            rx_data_q     <= rx_data_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            err_code_q    <= err_code_d;
            bit_cnt_q     <= bit_cnt_d;
            frame_count_q <= frame_count_d;
            tmo_q         <= tmo_d;
        end
    end

    // Next-state: frame reception, length validation and inactivity timeout.
    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        rx_data_d     = rx_data_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        err_code_d    = err_code_q;
        bit_cnt_d     = bit_cnt_q;
        frame_count_d = frame_count_q;
        tmo_d         = tmo_q;

        if (clr) begin
            // Abort wins over a coincident edge; last good frame is retained.
            state_d    = StIdle;
            bit_cnt_d  = '0;
            err_code_d = 2'b00;
            tmo_d      = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    tmo_d = '0;
                    if (edge_s && !syn_s) begin
                        shift_d[0] = din_s;
                        bit_cnt_d  = CNT_W'(1);
                        state_d    = StRecv;
                    end
                end
                StRecv, StOvf: begin
                    if (edge_s) begin
                        tmo_d = '0;
                        if (syn_s) begin
                            bit_cnt_d = '0;
                            state_d   = StIdle;
                            if (state_q == StRecv && bit_cnt_q == CNT_W'(TOTAL_BITS)) begin
                                rx_data_d     = shift_q;
                                frame_valid_d = 1'b1;
                                frame_count_d = frame_count_q + 16'd1;
                            end else begin
                                frame_err_d = 1'b1;
                                err_code_d  = (state_q == StOvf) ? 2'b10 : 2'b01;
                            end
                        end else if (state_q == StRecv) begin
                            if (bit_cnt_q < CNT_W'(TOTAL_BITS)) begin
                                shift_d[bit_cnt_q] = din_s;
                                bit_cnt_d          = bit_cnt_q + CNT_W'(1);
                            end else begin
                                state_d = StOvf;
                            end
                        end
                    end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                        frame_err_d = 1'b1;
                        err_code_d  = 2'b11;
                        bit_cnt_d   = '0;
                        tmo_d       = '0;
                        state_d     = StIdle;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign rx_data     = rx_data_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign err_code    = err_code_q;
    assign busy        = (state_q != StIdle);
    assign bit_cnt     = bit_cnt_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_din_syn_capture.sv
// Directed bench for din_syn_capture: good, short, long, timeout, rst, clr
// and back-to-back frames.
module tb_din_syn_capture;

    localparam int TB = 644;

    logic          clk_in = 1'b0;
    logic          rst = 1'b1;
    logic          sclk_in = 1'b0;
    logic          din_in = 1'b0;
    logic          syn_in = 1'b0;
    logic          clr = 1'b0;
    logic [TB-1:0] rx_data;
    logic          frame_valid;
    logic          frame_err;
    logic [1:0]    err_code;
    logic          busy;
    logic [9:0]    bit_cnt;
    logic [15:0]   frame_count;

    int checks = 0;
    int errors = 0;
    int vcnt = 0;
    int ecnt = 0;

    logic [TB-1:0] pat_alt;
    logic [TB-1:0] pat_b;
    logic [TB-1:0] pat_c;

    din_syn_capture #(.TOTAL_BITS(644), .CNT_W(10), .TIMEOUT(4095)) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .sclk_in     (sclk_in),
        .din_in      (din_in),
        .syn_in      (syn_in),
        .clr         (clr),
        .rx_data     (rx_data),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .err_code    (err_code),
        .busy        (busy),
        .bit_cnt     (bit_cnt),
        .frame_count (frame_count)
    );

    always #5 clk_in = ~clk_in;

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk_in) begin
        if (frame_valid === 1'b1) vcnt++;
        if (frame_err === 1'b1) ecnt++;
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    // One serial clock period: 4 cycles low, 4 cycles high.
    task automatic sclk_bit(input logic d, input logic s);
        sclk_in = 1'b0;
        din_in  = d;
        syn_in  = s;
        cycles(4);
        sclk_in = 1'b1;
        cycles(4);
    endtask

    task automatic send_bits(input logic [TB-1:0] pat, input int n);
        for (int i = 0; i < n; i++) sclk_bit((i < TB) ? pat[i] : 1'b0, 1'b0);
    endtask

    task automatic send_frame(input logic [TB-1:0] pat);
        send_bits(pat, TB);
        sclk_bit(1'b0, 1'b1);
        cycles(6);
    endtask

    task automatic test_reset;
        if (rx_data !== '0 || frame_valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got rx=%h v=%b e=%b busy=%b want 0", rx_data,
                     frame_valid, frame_err, busy);
        end
        checks++;
        if (err_code !== 2'b00 || bit_cnt !== 10'd0 || frame_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_counters got code=%b cnt=%0d fc=%0d want 0/0/0", err_code,
                     bit_cnt, frame_count);
        end
        checks++;
    endtask

    task automatic test_good_frame;
        int v0, e0;
        v0 = vcnt;
        e0 = ecnt;
        send_frame(pat_alt);
        if (vcnt - v0 !== 1 || ecnt - e0 !== 0) begin
            errors++;
            $display("FAIL good_pulses got valid=%0d err=%0d want 1/0", vcnt - v0, ecnt - e0);
        end
        checks++;
        if (rx_data !== pat_alt) begin
            errors++;
            $display("FAIL good_rx_data got %h want %h", rx_data, pat_alt);
        end
        checks++;
        if (frame_count !== 16'd1 || err_code !== 2'b00 || bit_cnt !== 10'd0) begin
            errors++;
            $display("FAIL good_status got fc=%0d code=%b cnt=%0d want 1/00/0", frame_count,
                     err_code, bit_cnt);
        end
        checks++;
    endtask

    task automatic test_short;
        int v0, e0;
        v0 = vcnt;
        e0 = ecnt;
        send_bits(pat_b, 10);
        if (bit_cnt !== 10'd10 || busy !== 1'b1) begin
            errors++;
            $display("FAIL short_partial got cnt=%0d busy=%b want 10/1", bit_cnt, busy);
        end
        checks++;
        sclk_bit(1'b0, 1'b1);
        cycles(6);
        if (ecnt - e0 !== 1 || vcnt - v0 !== 0 || err_code !== 2'b01) begin
            errors++;
            $display("FAIL short_err got err=%0d valid=%0d code=%b want 1/0/01", ecnt - e0,
                     vcnt - v0, err_code);
        end
        checks++;
        if (rx_data !== pat_alt || bit_cnt !== 10'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL short_keep got rx=%h cnt=%0d busy=%b want %h/0/0", rx_data, bit_cnt,
                     busy, pat_alt);
        end
        checks++;
    endtask

    task automatic test_overflow;
        int e0;
        e0 = ecnt;
        send_bits(pat_b, 650);
        if (busy !== 1'b1 || bit_cnt !== 10'd644 || ecnt - e0 !== 0) begin
            errors++;
            $display("FAIL ovf_hold got busy=%b cnt=%0d err=%0d want 1/644/0", busy, bit_cnt,
                     ecnt - e0);
        end
        checks++;
        sclk_bit(1'b0, 1'b1);
        cycles(6);
        if (ecnt - e0 !== 1 || err_code !== 2'b10 || frame_count !== 16'd1) begin
            errors++;
            $display("FAIL ovf_err got err=%0d code=%b fc=%0d want 1/10/1", ecnt - e0, err_code,
                     frame_count);
        end
        checks++;
        if (rx_data !== pat_alt || busy !== 1'b0 || bit_cnt !== 10'd0) begin
            errors++;
            $display("FAIL ovf_keep got rx=%h busy=%b cnt=%0d", rx_data, busy, bit_cnt);
        end
        checks++;
    endtask

    task automatic test_timeout;
        int e0, v0, cyc;
        e0 = ecnt;
        send_bits(pat_c, 100);
        sclk_in = 1'b0;
        cyc = 0;
        while (ecnt == e0 && cyc < 5000) begin
            cycles(1);
            cyc++;
        end
        // Abort lands TIMEOUT cycles after the last edge's action cycle.
        if (cyc < 4090 || cyc > 4100) begin
            errors++;
            $display("FAIL timeout_delay got %0d cycles want 4090..4100", cyc);
        end
        checks++;
        cycles(2);
        if (err_code !== 2'b11 || busy !== 1'b0 || bit_cnt !== 10'd0) begin
            errors++;
            $display("FAIL timeout_state got code=%b busy=%b cnt=%0d want 11/0/0", err_code,
                     busy, bit_cnt);
        end
        checks++;
        v0 = vcnt;
        send_frame(pat_b);
        if (vcnt - v0 !== 1 || rx_data !== pat_b || err_code !== 2'b11) begin
            errors++;
            $display("FAIL timeout_recover got valid=%0d code=%b rx=%h want 1/11/%h",
                     vcnt - v0, err_code, rx_data, pat_b);
        end
        checks++;
    endtask

    task automatic test_clr;
        int v0, e0;
        v0 = vcnt;
        e0 = ecnt;
        send_bits(pat_alt, 50);
        // 51st bit: clr coincides with the cycle the edge is acted upon.
        sclk_in = 1'b0;
        din_in  = 1'b1;
        syn_in  = 1'b0;
        cycles(4);
        sclk_in = 1'b1;
        cycles(2);
        clr = 1'b1;
        cycles(1);
        clr = 1'b0;
        cycles(3);
        if (bit_cnt !== 10'd0 || err_code !== 2'b00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clr_state got cnt=%0d code=%b busy=%b want 0/00/0", bit_cnt,
                     err_code, busy);
        end
        checks++;
        if (vcnt - v0 !== 0 || ecnt - e0 !== 0 || rx_data !== pat_b || frame_count !== 16'd2)
        begin
            errors++;
            $display("FAIL clr_keep got valid=%0d err=%0d fc=%0d want 0/0/2", vcnt - v0,
                     ecnt - e0, frame_count);
        end
        checks++;
        send_frame(pat_c);
        if (vcnt - v0 !== 1 || rx_data !== pat_c || frame_count !== 16'd3) begin
            errors++;
            $display("FAIL clr_next got valid=%0d fc=%0d rx=%h want 1/3/%h", vcnt - v0,
                     frame_count, rx_data, pat_c);
        end
        checks++;
    endtask

    task automatic test_rst_mid;
        int v0;
        send_bits(pat_b, 300);
        sclk_in = 1'b0;
        cycles(4);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        cycles(2);
        if (rx_data !== '0 || frame_count !== 16'd0 || bit_cnt !== 10'd0 || busy !== 1'b0 ||
            err_code !== 2'b00) begin
            errors++;
            $display("FAIL rst_mid got rx=%h fc=%0d cnt=%0d busy=%b code=%b want all 0",
                     rx_data, frame_count, bit_cnt, busy, err_code);
        end
        checks++;
        v0 = vcnt;
        send_frame(pat_alt);
        if (vcnt - v0 !== 1 || rx_data !== pat_alt || frame_count !== 16'd1) begin
            errors++;
            $display("FAIL rst_next got valid=%0d fc=%0d rx=%h want 1/1/%h", vcnt - v0,
                     frame_count, rx_data, pat_alt);
        end
        checks++;
    endtask

    task automatic test_back_to_back;
        int v0, e0;
        v0 = vcnt;
        e0 = ecnt;
        send_bits(pat_b, TB);
        sclk_bit(1'b0, 1'b1);
        send_bits(pat_c, TB);
        sclk_bit(1'b0, 1'b1);
        // Sync held over a second serial clock: stray, ignored in IDLE.
        sclk_bit(1'b0, 1'b1);
        cycles(6);
        if (vcnt - v0 !== 2 || ecnt - e0 !== 0 || frame_count !== 16'd3) begin
            errors++;
            $display("FAIL b2b_count got valid=%0d err=%0d fc=%0d want 2/0/3", vcnt - v0,
                     ecnt - e0, frame_count);
        end
        checks++;
        if (rx_data !== pat_c || busy !== 1'b0 || err_code !== 2'b00) begin
            errors++;
            $display("FAIL b2b_data got rx=%h busy=%b code=%b want %h/0/00", rx_data, busy,
                     err_code, pat_c);
        end
        checks++;
    endtask

    initial begin
        for (int i = 0; i < TB; i++) begin
            pat_alt[i] = i[0];
            pat_b[i]   = (i % 3 == 0);
            pat_c[i]   = (i % 5 == 1) || (i % 7 == 3);
        end
        cycles(3);
        rst = 1'b0;
        cycles(2);
        test_reset;
        test_good_frame;
        test_short;
        test_overflow;
        test_timeout;
        test_clr;
        test_rst_mid;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
